// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the program counter, addresses the asynchronous instruction memory and
// captures each returned instruction with its PC for the decode stage.
// A redirect reloads the PC and flushes IF/ID. A stall freezes PC and IF/ID.
// Fetching past the end of instruction memory parks the stage in HALT until
// a redirect arrives.
module fetch_ifid_stage #(
    parameter longint unsigned IMEM_DEPTH = 256,
    parameter int              ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       pc,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // 33 bits so that a depth of exactly 2^32 is representable
    localparam logic [32:0] DEPTH_LIMIT = 33'(IMEM_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic        ifid_valid_next;
    logic [31:0] ifid_instr_next;
    logic [31:0] ifid_pc_next;
    logic [31:0] fetch_count_next;
    logic        pc_in_range;

    assign imem_addr   = pc[ADDR_W-1:0];
    assign halted      = (state == HALT);
    assign pc_in_range = ({1'b0, pc} < DEPTH_LIMIT);

    // Next-state and next-register values; priority is redirect, then stall,
    // then normal advance (reset is applied in the register process)
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        ifid_valid_next  = ifid_valid;
        ifid_instr_next  = ifid_instr;
        ifid_pc_next     = ifid_pc;
        fetch_count_next = fetch_count;

        case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_next         = redirect_target;
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = 32'd0;
                    ifid_pc_next    = 32'd0;
                end else if (stall) begin
                    pc_next = pc;
                end else if (pc_in_range) begin
                    ifid_valid_next  = 1'b1;
                    ifid_instr_next  = imem_data;
                    ifid_pc_next     = pc;
                    pc_next          = pc + 32'd1;
                    fetch_count_next = fetch_count + 32'd1;
                end else begin
                    ifid_valid_next = 1'b0;
                    ifid_instr_next = 32'd0;
                    state_next      = HALT;
                end
            end
            HALT: begin
                ifid_valid_next = 1'b0;
                ifid_instr_next = 32'd0;
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State, PC, IF/ID and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            pc          <= 32'd0;
            ifid_valid  <= 1'b0;
            ifid_instr  <= 32'd0;
            ifid_pc     <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ifid_valid  <= ifid_valid_next;
            ifid_instr  <= ifid_instr_next;
            ifid_pc     <= ifid_pc_next;
            fetch_count <= fetch_count_next;
        end
    end

endmodule
